// File: rtl/seg_display_driver.sv
// -----------------------------------------------------------------------------
// seg_display_driver
//
// Time-multiplexed driver for a 4-digit, common-anode 7-segment display showing
// HH:MM from a clock block. Digits are scanned right to left, one slot per
// REFRESH_DIV clocks. A snapshot of the inputs is taken once per frame, so a
// frame never mixes an old and a new time. In edit mode the whole display
// blinks with a period of 2*BLINK_DIV clocks.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous, active-high reset
//   fmt            : 1 = 12-hour format (enables leading-zero blank, PM dot)
//   ampm           : 1 = PM
//   edit           : 1 = edit mode (display blinks)
//   hrL, hrR       : BCD hour tens / ones
//   mL, mR         : BCD minute tens / ones
//   an[3:0]        : active-low anode enables, an[0] = rightmost digit
//   seg[6:0]       : active-low segments {g,f,e,d,c,b,a}
//   dp             : active-low decimal point
// -----------------------------------------------------------------------------
module seg_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fmt,
    input  logic       ampm,
    input  logic       edit,
    input  logic [3:0] hrL,
    input  logic [3:0] hrR,
    input  logic [3:0] mL,
    input  logic [3:0] mR,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef struct packed {
        logic       fmt;
        logic       ampm;
        logic       edit;
        logic [3:0] hr_l;
        logic [3:0] hr_r;
        logic [3:0] m_l;
        logic [3:0] m_r;
    } snap_t;

    // Active-low BCD decode; 10..15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    snap_t         snap_q, snap_d;
    // Set by reset: the snapshot is stale until the first cycle after reset
    // reloads it, so the display stays dark for that one cycle.
    logic          load_pend_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          refresh_wrap;
    logic          snap_load;
    logic [3:0]    digit;
    logic          blank;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        refresh_wrap  = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
        slot_d        = refresh_wrap ? slot_q + 2'd1 : slot_q;

        // Reload at the frame boundary (slot 3 -> 0) or right after reset.
        snap_load = load_pend_q || (refresh_wrap && (slot_q == 2'd3));
        snap_d    = snap_q;
        if (snap_load) begin
            snap_d = '{fmt: fmt, ampm: ampm, edit: edit,
                       hr_l: hrL, hr_r: hrR, m_l: mL, m_r: mR};
        end

        // The blink timer follows the live edit input, not the snapshot.
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (edit) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
                blink_phase_d = blink_phase_q;
            end
        end

        // Outputs are built from the registered slot and snapshot, giving one
        // cycle of latency after any slot change or snapshot load.
        case (slot_q)
            2'd0:    digit = snap_q.m_r;
            2'd1:    digit = snap_q.m_l;
            2'd2:    digit = snap_q.hr_r;
            default: digit = snap_q.hr_l;
        endcase

        blank = load_pend_q
              || (snap_q.edit && blink_phase_q)
              || ((slot_q == 2'd3) && snap_q.fmt && (snap_q.hr_l == 4'd0));

        an_d  = ~(4'b0001 << slot_q);
        seg_d = bcd_to_seg(digit);
        dp_d  = ~((slot_q == 2'd2)
               || ((slot_q == 2'd0) && snap_q.fmt && snap_q.ampm));
        if (blank) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            slot_q        <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= '0;
            load_pend_q   <= 1'b1;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            load_pend_q   <= 1'b0;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 Parameter BLINK_DIV, default 50000000, SHALL set the clk cycles per blink-phase toggle (0.5 s).
REQ-003 Port clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Ports fmt, ampm, edit  input  1 each  SHALL carry, in order: 12h format (1=12h), PM flag (1=PM), and edit mode active, all from the clock block.
REQ-006 Ports hrL, hrR, mL, mR  input  4 each  SHALL carry the BCD hour-tens, hour-ones, minute-tens and minute-ones digits.
REQ-007 Port an  output  4  SHALL carry the active-low anode enables; an[0] is the rightmost digit.
REQ-008 Port seg  output  7  SHALL carry the active-low segments {g,f,e,d,c,b,a}.
REQ-009 Port dp  output  1  SHALL carry the active-low decimal point.

Function
REQ-010 refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap cycle, the 2-bit slot index SHALL advance 0->1->2->3->0.
REQ-011 Slot mapping SHALL be: slot0 = mR on an[0]; slot1 = mL on an[1]; slot2 = hrR on an[2]; slot3 = hrL on an[3].
REQ-012 A snapshot register of {fmt, ampm, edit, hrL, hrR, mL, mR} SHALL load only on the cycle the slot index goes 3->0, so that each frame shows one coherent time.
REQ-013 The snapshot SHALL also load on the first cycle after rst deasserts.
REQ-014 BCD decode (hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any value 10-15 SHALL decode to a dash, 3F.
REQ-015 Leading-zero blank: when snapshot fmt=1 and snapshot hrL=0, slot3 SHALL drive an=1111.
REQ-016 dp SHALL be 0 (lit) during slot2, as the hour/minute separator.
REQ-017 dp SHALL be 0 during slot0 when snapshot fmt=1 and ampm=1 (PM indicator); otherwise dp SHALL be 1.
REQ-018 While the live edit input is 1, blink_cnt SHALL count 0..BLINK_DIV-1 and toggle blink_phase on each wrap.
REQ-019 While the live edit input is 0, blink_cnt and blink_phase SHALL be held at 0.
REQ-020 When snapshot edit=1 and blink_phase=1, an SHALL be 1111; seg and dp are don't-care.
REQ-021 Exactly one anode SHALL be low in any cycle, or none when blanked; two anodes SHALL never be low together.
REQ-022 an, seg and dp SHALL be registered; outputs SHALL reflect a new slot index one cycle after the index changes.
REQ-023 The input-to-display latency SHALL be at most 4*REFRESH_DIV+2 cycles.
REQ-024 When a snapshot load and a slot advance occur in the same cycle, the new slot SHALL display the newly loaded snapshot, with the same one-cycle output latency as REQ-022.

Reset
REQ-025 While rst=1 the following SHALL be cleared: refresh_cnt=0, slot=0, blink_cnt=0, blink_phase=0, snapshot=0.
REQ-026 While rst=1 the outputs SHALL be an=1111, seg=7F, dp=1.
REQ-027 rst asserted mid-frame or mid-blink SHALL take effect on the next clock edge, with no partial-slot output afterwards.
REQ-028 After rst deasserts, the first lit slot SHALL be slot0, on the second cycle after deassert.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-029 Scan test: fmt=0, hrL/hrR/mL/mR=1/3/4/5, edit=0 -> an cycles 1110,1101,1011,0111 with 4 cycles each; seg=12,19,30,79 respectively; dp=0 only on an=1011.
REQ-030 12h blanking test: fmt=1, ampm=1, hrL=0, hrR=9 -> an[3] never low; slot0 dp=0; slot2 seg=10.
REQ-031 Invalid digit test: mR=4'hC -> slot0 seg=3F.
REQ-032 Coherence test: change mR from 4 to 5 in the middle of slot1 -> slot0 keeps showing 19 until after the next 3->0 transition, then shows 12.
REQ-033 Blink test: edit=1 for 64 cycles -> an=1111 during cycles 16-31 and 48-63 (after snapshot); dropping edit to 0 -> blink_phase=0 next cycle and digits lit after the next snapshot load.
REQ-034 Reset test: assert rst during slot2 with edit blinking -> next cycle an=1111, seg=7F, dp=1; after deassert, slot0 is first lit.
